// File: rtl/keypad_pkg.sv
// Shared types, default timing parameters and key-code mapping for the keypad scanner.
package keypad_pkg;

    localparam int unsigned SCAN_DIV_DEF   = 1000;
    localparam int unsigned DEB_CYCLES_DEF = 20000;

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_EMIT     = 2'd2,
        ST_RELEASE  = 2'd3
    } kp_state_e;

    // Code = row_index*4 + col_index; with several rows set the lowest row wins.
    function automatic logic [3:0] key_code_f(input logic [3:0] rows, input logic [3:0] cols);
        logic [1:0] r_idx;
        logic [1:0] c_idx;
        r_idx = 2'd0;
        c_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (rows[i]) r_idx = 2'(i);
        end
        for (int i = 0; i < 4; i++) begin
            if (cols[i]) c_idx = 2'(i);
        end
        return {r_idx, c_idx};
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for one asynchronous input bit.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad scanner: column rotation, press/release debounce, ready/valid key
// hand-off and a four-digit history of accepted codes.
module keypad_scan_ctrl
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV   = SCAN_DIV_DEF,
    parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  row_in,
    output logic [3:0]  col_out,
    output logic [3:0]  key_code,
    output logic        key_valid,
    input  logic        key_ready,
    output logic [15:0] digits,
    output logic        busy
);

    localparam int unsigned DIV_W = (SCAN_DIV   > 1) ? $clog2(SCAN_DIV)   : 1;
    localparam int unsigned CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

    kp_state_e          state_q, state_d;
    logic [3:0]         col_q, col_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [3:0]         latch_q, latch_d;
    logic [3:0]         code_q, code_d;
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;
    logic [15:0]        digits_q, digits_d;
    logic [3:0]         rows;

    logic slot_end;
    logic cnt_done;
    logic deb_match;
    logic [3:0] col_next;

    for (genvar g = 0; g < 4; g++) begin : g_row_sync
        sync_2ff u_sync (
            .clk (clk),
            .rst (rst),
            .d_i (row_in[g]),
            .q_o (rows[g])
        );
    end

    assign slot_end  = (div_q == DIV_W'(SCAN_DIV - 1));
    assign cnt_done  = (cnt_q == CNT_W'(DEB_CYCLES - 1));
    assign deb_match = (rows == latch_q);
    assign col_next  = {col_q[2:0], col_q[3]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_SCAN;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_SCAN:     if (slot_end && (rows != 4'b0)) state_d = ST_DEBOUNCE;
            ST_DEBOUNCE: begin
                if (!deb_match)    state_d = ST_SCAN;
                else if (cnt_done) state_d = ST_EMIT;
            end
            ST_EMIT:     if (key_ready) state_d = ST_RELEASE;
            ST_RELEASE:  if ((rows == 4'b0) && cnt_done) state_d = ST_SCAN;
            default:     state_d = ST_SCAN;
        endcase
    end

    // Datapath next values; col_out stays frozen outside SCAN so the pressed key keeps driving.
    always_comb begin
        col_d    = col_q;
        div_d    = div_q;
        cnt_d    = cnt_q;
        latch_d  = latch_q;
        code_d   = code_q;
        valid_d  = valid_q;
        digits_d = digits_q;
        case (state_q)
            ST_SCAN: begin
                if (slot_end) begin
                    div_d = '0;
                    if (rows != 4'b0) begin
                        latch_d = rows;
                        cnt_d   = '0;
                    end else begin
                        col_d = col_next;
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            ST_DEBOUNCE: begin
                if (!deb_match) begin
                    col_d = col_next;
                    div_d = '0;
                end else if (cnt_done) begin
                    code_d  = key_code_f(latch_q, col_q);
                    valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_EMIT: begin
                if (key_ready) begin
                    digits_d = {digits_q[11:0], code_q};
                    valid_d  = 1'b0;
                    cnt_d    = '0;
                end
            end
            ST_RELEASE: begin
                if (rows != 4'b0) begin
                    cnt_d = '0;
                end else if (cnt_done) begin
                    col_d = col_next;
                    div_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: ;
        endcase
        busy_d = (state_d != ST_SCAN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q    <= 4'b0001;
            div_q    <= '0;
            cnt_q    <= '0;
            latch_q  <= 4'b0;
            code_q   <= 4'b0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            digits_q <= 16'h0000;
        end else begin
            col_q    <= col_d;
            div_q    <= div_d;
            cnt_q    <= cnt_d;
            latch_q  <= latch_d;
            code_q   <= code_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            digits_q <= digits_d;
        end
    end

    assign col_out   = col_q;
    assign key_code  = code_q;
    assign key_valid = valid_q;
    assign digits    = digits_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed bench for keypad_scan_ctrl using a simple keypad model driven by col_out.
module tb_keypad_scan_ctrl;

    localparam int unsigned SCAN_DIV   = 4;
    localparam int unsigned DEB_CYCLES = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  row_in;
    logic [3:0]  col_out;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_ready;
    logic [15:0] digits;
    logic        busy;

    logic        press_en;
    logic [3:0]  key_rows;
    logic [1:0]  key_col;
    logic        ovr_en;
    logic [3:0]  ovr_val;

    int checks = 0;
    int errors = 0;
    int valid_cycles = 0;

    always #5 clk = ~clk;

    // Keypad model: a held key connects its column drive to its row(s).
    assign row_in = ovr_en ? ovr_val :
                    ((press_en && col_out[key_col]) ? key_rows : 4'b0000);

    always @(negedge clk) if (!rst && key_valid) valid_cycles++;

    keypad_scan_ctrl #(
        .SCAN_DIV   (SCAN_DIV),
        .DEB_CYCLES (DEB_CYCLES)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .row_in    (row_in),
        .col_out   (col_out),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .digits    (digits),
        .busy      (busy)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (key_valid !== 1'b1 && n < 300) begin
            tick();
            n++;
        end
        check_eq({tag, "_valid_seen"}, 32'(key_valid), 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy !== 1'b0 && n < 300) begin
            tick();
            n++;
        end
        check_eq({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    task automatic press_release(input string tag, input logic [3:0] rows, input logic [1:0] col,
                                 input logic [3:0] exp_code);
        int v0;
        v0        = valid_cycles;
        key_ready = 1'b1;
        key_rows  = rows;
        key_col   = col;
        press_en  = 1'b1;
        wait_valid(tag);
        check_eq({tag, "_code"}, 32'(key_code), 32'(exp_code));
        tick();
        check_eq({tag, "_valid_drop"}, 32'(key_valid), 32'd0);
        check_eq({tag, "_valid_cycles"}, 32'(valid_cycles - v0), 32'd1);
        press_en = 1'b0;
        wait_idle(tag);
    endtask

    initial begin
        int v0;
        rst       = 1'b1;
        key_ready = 1'b0;
        press_en  = 1'b0;
        key_rows  = 4'b0;
        key_col   = 2'd0;
        ovr_en    = 1'b0;
        ovr_val   = 4'b0;
        tick();
        tick();
        check_eq("rst_col",    32'(col_out),   32'h1);
        check_eq("rst_code",   32'(key_code),  32'h0);
        check_eq("rst_valid",  32'(key_valid), 32'h0);
        check_eq("rst_digits", 32'(digits),    32'h0);
        check_eq("rst_busy",   32'(busy),      32'h0);
        rst = 1'b0;

        // Single key row1/col2 -> code 6.
        press_release("key6", 4'b0010, 2'd2, 4'h6);
        check_eq("key6_digits", 32'(digits), 32'h0006);
        check_eq("key6_next_col", 32'(col_out), 32'b1000);

        // Five keys, history keeps the newest four.
        press_release("key1", 4'b0001, 2'd1, 4'h1);
        press_release("key2", 4'b0001, 2'd2, 4'h2);
        press_release("key3", 4'b0001, 2'd3, 4'h3);
        press_release("key4", 4'b0010, 2'd0, 4'h4);
        press_release("key5", 4'b0010, 2'd1, 4'h5);
        check_eq("seq_digits", 32'(digits), 32'h2345);

        // Bounce for 5 cycles then release: no key accepted.
        v0     = valid_cycles;
        ovr_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            ovr_val = (i % 2 == 0) ? 4'b0001 : 4'b0000;
            tick();
        end
        ovr_val = 4'b0000;
        for (int i = 0; i < 40; i++) tick();
        ovr_en = 1'b0;
        check_eq("bounce_no_valid", 32'(valid_cycles - v0), 32'd0);
        check_eq("bounce_busy",     32'(busy),   32'd0);
        check_eq("bounce_digits",   32'(digits), 32'h2345);

        // Consumer stalls 10 cycles in EMIT.
        key_ready = 1'b0;
        key_rows  = 4'b0100;
        key_col   = 2'd3;
        press_en  = 1'b1;
        wait_valid("stall");
        for (int i = 0; i < 10; i++) begin
            tick();
            check_eq("stall_valid",  32'(key_valid), 32'd1);
            check_eq("stall_code",   32'(key_code),  32'hB);
            check_eq("stall_digits", 32'(digits),    32'h2345);
        end
        key_ready = 1'b1;
        tick();
        check_eq("stall_valid_drop", 32'(key_valid), 32'd0);
        check_eq("stall_digits_upd", 32'(digits),    32'h345B);
        press_en = 1'b0;
        wait_idle("stall");

        // Two rows on column 3: lowest row wins, no second code while held.
        v0        = valid_cycles;
        key_ready = 1'b1;
        key_rows  = 4'b0101;
        key_col   = 2'd3;
        press_en  = 1'b1;
        wait_valid("multi");
        check_eq("multi_code", 32'(key_code), 32'h3);
        for (int i = 0; i < 60; i++) tick();
        check_eq("multi_one_code", 32'(valid_cycles - v0), 32'd1);
        check_eq("multi_busy_held", 32'(busy), 32'd1);
        press_en = 1'b0;
        wait_idle("multi");
        check_eq("multi_digits", 32'(digits), 32'h45B3);

        // Reset while a key waits in EMIT.
        key_ready = 1'b0;
        key_rows  = 4'b1000;
        key_col   = 2'd0;
        press_en  = 1'b1;
        wait_valid("abort");
        check_eq("abort_code_pre", 32'(key_code), 32'hC);
        rst = 1'b1;
        #1;
        check_eq("abort_valid",  32'(key_valid), 32'd0);
        check_eq("abort_col",    32'(col_out),   32'h1);
        check_eq("abort_digits", 32'(digits),    32'h0);
        check_eq("abort_busy",   32'(busy),      32'd0);
        check_eq("abort_code",   32'(key_code),  32'h0);
        press_en = 1'b0;
        tick();
        rst = 1'b0;

        // Scanning restarts at column 0 for a full slot.
        repeat (3) @(posedge clk);
        #1;
        check_eq("restart_col0", 32'(col_out), 32'b0001);
        @(posedge clk);
        #1;
        check_eq("restart_col1", 32'(col_out), 32'b0010);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
